// File: rtl/mult_pad_serdes.sv
// Serial pad front end for the approximate multiplier: deserialises A/B LSB-first,
// waits MUL_LAT cycles for the combinational core, then streams both product halves out.
module mult_pad_serdes #(
    parameter int OP_W    = 16,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              a_pad,
    input  logic              b_pad,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    input  logic [2*OP_W-1:0] prod,
    output logic              out_valid,
    output logic              out_lo,
    output logic              out_hi,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W  = $clog2(OP_W);
    localparam int WAIT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(OP_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {LOAD, CALC, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [OP_W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2*OP_W-1:0]   sreg_q, sreg_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            wait_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sreg_q  <= sreg_d;
        end
    end

    // One index serves both the load position and the output bit position.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sreg_d  = sreg_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    op_a_d[idx_q] = a_pad;
                    op_b_d[idx_q] = b_pad;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        wait_d  = WAIT_INIT;
                        state_d = CALC;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CALC: begin
                if (wait_q == '0) begin
                    sreg_d  = prod;
                    idx_d   = '0;
                    state_d = SHIFT;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            SHIFT: begin
                // Each half shifts independently so bit 0 and bit OP_W are always current.
                sreg_d = {1'b0, sreg_q[2*OP_W-1:OP_W+1], 1'b0, sreg_q[OP_W-1:1]};
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign out_valid = (state_q == SHIFT);
    assign out_lo    = out_valid & sreg_q[0];
    assign out_hi    = out_valid & sreg_q[OP_W];
    assign busy      = (state_q != LOAD);
    assign done      = out_valid & (idx_q == IDX_LAST);

endmodule
